// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI target: register selects, FSM
// states, STATUS bit positions and the STATUS word builder.
package hpi_pkg;

  localparam int DATA_W = 16;

  // Host register select on OTG_ADDR
  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDR    = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  // Host access state machine
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_ACT = 2'd1,
    ST_RD_ACT = 2'd2
  } hpi_state_e;

  // STATUS register bit positions
  localparam int STAT_OUT_FULL_BIT  = 0;
  localparam int STAT_IN_VALID_BIT  = 8;
  localparam int STAT_PROTO_ERR_BIT = 15;

  // Byte-address auto-increment by one 16-bit word; wraps FFFE -> 0000
  function automatic logic [DATA_W-1:0] next_addr(input logic [DATA_W-1:0] a);
    return a + 16'd2;
  endfunction

  // Assemble the STATUS word from the three flags, all other bits zero
  function automatic logic [DATA_W-1:0] status_word(input logic out_full,
                                                    input logic in_valid,
                                                    input logic perr);
    logic [DATA_W-1:0] s;
    s = '0;
    s[STAT_OUT_FULL_BIT]  = out_full;
    s[STAT_IN_VALID_BIT]  = in_valid;
    s[STAT_PROTO_ERR_BIT] = perr;
    return s;
  endfunction

endpackage

// File: rtl/hpi_target_mem.sv
// Single-port synchronous RAM, one-cycle read latency, read-first on write.
// Contents are intentionally not reset.
module hpi_target_mem
  import hpi_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**MEM_AW)-1];

  // Registered read of the addressed word, optional write of the same word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hpi_target.sv
// HPI host-port target: host accesses DATA (auto-incrementing memory window),
// MAILBOX, ADDRESS and STATUS registers over a strobed 16-bit tristate bus;
// a device-side mailbox pair lets local logic exchange words with the host.
module hpi_target
  import hpi_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  inout  wire  [DATA_W-1:0] OTG_DATA,
  input  logic [1:0]        OTG_ADDR,
  input  logic              OTG_CS_N,
  input  logic              OTG_RD_N,
  input  logic              OTG_WR_N,
  input  logic              OTG_RST_N,
  output logic              OTG_INT,
  input  logic              dev_mbx_wr,
  input  logic [DATA_W-1:0] dev_mbx_wdata,
  output logic [DATA_W-1:0] dev_mbx_in,
  output logic              dev_mbx_in_valid,
  input  logic              dev_mbx_ack,
  output logic              proto_err
);

  hpi_state_e        state;
  hpi_reg_e          sel;
  hpi_reg_e          rd_sel;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_hold;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_val;
  logic              out_full;
  logic              rst;
  logic              cs, rd, wr;
  logic              wr_start, rd_start, rd_exit, wr_exit, both_low;
  logic              ram_we;

  assign rst = Reset | ~OTG_RST_N;
  assign cs  = ~OTG_CS_N;
  assign rd  = ~OTG_RD_N;
  assign wr  = ~OTG_WR_N;
  assign sel = hpi_reg_e'(OTG_ADDR);

  assign wr_start = (state == ST_IDLE) && cs && wr && !rd;
  assign rd_start = (state == ST_IDLE) && cs && rd && !wr;
  assign both_low = cs && rd && wr;
  assign wr_exit  = (state == ST_WR_ACT) && (!cs || !wr);
  assign rd_exit  = (state == ST_RD_ACT) && (!cs || !rd);

  // A DATA write lands in the word selected by the current address before it advances
  assign ram_we = wr_start && (sel == HPI_DATA) && !rst;

  hpi_target_mem #(
    .MEM_AW(MEM_AW)
  ) u_mem (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (addr_q[MEM_AW:1]),
    .wdata (OTG_DATA),
    .rdata (ram_rdata)
  );

  // DATA reads come straight from the RAM output (address is frozen while
  // RD_ACT), every other register from the snapshot taken at read start
  assign rd_data  = (rd_sel == HPI_DATA) ? ram_rdata : rd_hold;
  assign OTG_DATA = (state == ST_RD_ACT) ? rd_data : {DATA_W{1'bz}};
  assign OTG_INT  = out_full;

  // Host access FSM with the address register and its auto-increment
  always_ff @(posedge Clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      rd_sel <= HPI_DATA;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_start) begin
            state <= ST_WR_ACT;
            case (sel)
              HPI_ADDR: addr_q <= OTG_DATA;
              HPI_DATA: addr_q <= next_addr(addr_q);
              default:  addr_q <= addr_q;
            endcase
          end else if (rd_start) begin
            state  <= ST_RD_ACT;
            rd_sel <= sel;
          end
        end
        ST_WR_ACT: begin
          if (wr_exit) begin
            state <= ST_IDLE;
          end
        end
        ST_RD_ACT: begin
          if (rd_exit) begin
            state <= ST_IDLE;
            if (rd_sel == HPI_DATA) begin
              addr_q <= next_addr(addr_q);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Snapshot of the non-memory register selected at read start
  always_ff @(posedge Clk) begin
    if (rd_start) begin
      case (sel)
        HPI_MAILBOX: rd_hold <= out_val;
        HPI_ADDR:    rd_hold <= addr_q;
        HPI_STATUS:  rd_hold <= status_word(out_full, dev_mbx_in_valid, proto_err);
        default:     rd_hold <= '0;
      endcase
    end
  end

  // Device-to-host mailbox: a device post beats a same-cycle host read clear
  always_ff @(posedge Clk) begin
    if (rst) begin
      out_full <= 1'b0;
      out_val  <= '0;
    end else if (dev_mbx_wr) begin
      out_full <= 1'b1;
      out_val  <= dev_mbx_wdata;
    end else if (rd_exit && (rd_sel == HPI_MAILBOX)) begin
      out_full <= 1'b0;
    end
  end

  // Host-to-device mailbox: a host write beats a same-cycle device ack
  always_ff @(posedge Clk) begin
    if (rst) begin
      dev_mbx_in       <= '0;
      dev_mbx_in_valid <= 1'b0;
    end else if (wr_start && (sel == HPI_MAILBOX)) begin
      dev_mbx_in       <= OTG_DATA;
      dev_mbx_in_valid <= 1'b1;
    end else if (dev_mbx_ack) begin
      dev_mbx_in_valid <= 1'b0;
    end
  end

  // Sticky flag for simultaneous read and write strobes under chip select
  always_ff @(posedge Clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (both_low) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hpi_target.sv
// Bench for hpi_target: table of host/device transactions with fixed expected
// values, hand-written corner sequences, and a randomized run checked against
// a transaction-level model of the register file, memory and mailboxes.
module tb_hpi_target;

  localparam int MEM_AW = 8;
  localparam int MEM_WORDS = 1 << MEM_AW;

  localparam int OP_HW  = 0;  // host write: sel, data
  localparam int OP_HR  = 1;  // host read: sel, compare to exp
  localparam int OP_DW  = 2;  // device posts data
  localparam int OP_ACK = 3;  // device acks host mailbox
  localparam int OP_INT = 4;  // OTG_INT must equal exp[0]
  localparam int OP_MBX = 5;  // dev_mbx_in must equal data, valid exp[0]

  typedef struct {
    int          op;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        otg_rst_n;
  logic        cs_n, rd_n, wr_n;
  logic [1:0]  otg_addr;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  tri1  [15:0] otg_data;
  logic        otg_int;
  logic        dev_mbx_wr;
  logic [15:0] dev_mbx_wdata;
  logic [15:0] dev_mbx_in;
  logic        dev_mbx_in_valid;
  logic        dev_mbx_ack;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  assign otg_data = tb_drv ? tb_wdata : 16'bz;

  always #10 clk = ~clk;

  hpi_target #(.MEM_AW(MEM_AW)) dut (
    .Clk              (clk),
    .Reset            (rst),
    .OTG_DATA         (otg_data),
    .OTG_ADDR         (otg_addr),
    .OTG_CS_N         (cs_n),
    .OTG_RD_N         (rd_n),
    .OTG_WR_N         (wr_n),
    .OTG_RST_N        (otg_rst_n),
    .OTG_INT          (otg_int),
    .dev_mbx_wr       (dev_mbx_wr),
    .dev_mbx_wdata    (dev_mbx_wdata),
    .dev_mbx_in       (dev_mbx_in),
    .dev_mbx_in_valid (dev_mbx_in_valid),
    .dev_mbx_ack      (dev_mbx_ack),
    .proto_err        (proto_err)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_mem   [0:MEM_WORDS-1];
  bit          m_known [0:MEM_WORDS-1];
  logic [15:0] m_addr, m_out_val, m_in_val;
  bit          m_out_full, m_in_valid, m_proto;

  function automatic int m_idx(input logic [15:0] a);
    return (int'(a) / 2) % MEM_WORDS;
  endfunction

  function automatic logic [15:0] m_status();
    return 16'(m_proto * 32768 + m_in_valid * 256 + m_out_full);
  endfunction

  task automatic m_reset();
    m_addr = 0; m_out_val = 0; m_in_val = 0;
    m_out_full = 0; m_in_valid = 0; m_proto = 0;
  endtask

  task automatic m_host_write(input logic [1:0] sel, input logic [15:0] d);
    case (sel)
      2'd0: begin
        m_mem[m_idx(m_addr)] = d;
        m_known[m_idx(m_addr)] = 1;
        m_addr = m_addr + 16'd2;
      end
      2'd1: begin m_in_val = d; m_in_valid = 1; end
      2'd2: m_addr = d;
      default: ;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_side(input string tag);
    @(negedge clk);
    check16({tag, "_int"}, {15'b0, otg_int}, {15'b0, m_out_full});
    check16({tag, "_mbx_in"}, dev_mbx_in, m_in_val);
    check16({tag, "_flags"}, {14'b0, dev_mbx_in_valid, proto_err}, {14'b0, m_in_valid, m_proto});
  endtask

  // ---------------- bus tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [15:0] d, input bit ack_same);
    otg_addr = sel; tb_wdata = d; tb_drv = 1; cs_n = 0; wr_n = 0;
    dev_mbx_ack = ack_same;
    tick();
    dev_mbx_ack = 0; cs_n = 1; wr_n = 1; tb_drv = 0;
    tick();
    m_host_write(sel, d);
  endtask

  // Returns the sampled bus value, the model's expectation and whether it is known
  task automatic host_read(input logic [1:0] sel, input bit devwr_exit, input logic [15:0] devwr_d,
                           output logic [15:0] got, output logic [15:0] exp, output bit known);
    known = 1;
    case (sel)
      2'd0: begin
        exp = m_mem[m_idx(m_addr)]; known = m_known[m_idx(m_addr)];
        m_addr = m_addr + 16'd2;
      end
      2'd1: begin exp = m_out_val; m_out_full = 0; end
      2'd2: exp = m_addr;
      default: exp = m_status();
    endcase
    if (devwr_exit) begin m_out_full = 1; m_out_val = devwr_d; end
    otg_addr = sel; cs_n = 0; rd_n = 0;
    tick();
    @(negedge clk);
    got = otg_data;
    if (devwr_exit) begin dev_mbx_wr = 1; dev_mbx_wdata = devwr_d; end
    cs_n = 1; rd_n = 1;
    tick();
    dev_mbx_wr = 0;
  endtask

  task automatic dev_write(input logic [15:0] d);
    dev_mbx_wr = 1; dev_mbx_wdata = d;
    tick();
    dev_mbx_wr = 0;
    m_out_full = 1; m_out_val = d;
  endtask

  task automatic dev_ack();
    dev_mbx_ack = 1;
    tick();
    dev_mbx_ack = 0;
    m_in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    m_reset();
  endtask

  function automatic vec_t v(input int op, input logic [1:0] sel, input logic [15:0] d, input logic [15:0] e);
    vec_t r;
    r.op = op; r.sel = sel; r.data = d; r.exp = e;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [15:0] got, exp;
    bit          known;

    rst = 1; otg_rst_n = 1; cs_n = 1; rd_n = 1; wr_n = 1; otg_addr = 0;
    tb_drv = 0; tb_wdata = 0; dev_mbx_wr = 0; dev_mbx_wdata = 0; dev_mbx_ack = 0;
    for (int i = 0; i < MEM_WORDS; i++) begin m_known[i] = 0; m_mem[i] = 0; end
    m_reset();
    do_reset();

    // Reset state
    check_side("reset");
    check16("reset_bus_hiz", otg_data, 16'hFFFF);
    host_read(2'd2, 0, 0, got, exp, known);
    check16("reset_addr", got, 16'h0000);
    host_read(2'd3, 0, 0, got, exp, known);
    check16("reset_status", got, 16'h0000);

    // Directed transaction table
    vecs.push_back(v(OP_HW, 2'd2, 16'h0010, 0));
    vecs.push_back(v(OP_HW, 2'd0, 16'hBEEF, 0));
    vecs.push_back(v(OP_HW, 2'd0, 16'h1234, 0));
    vecs.push_back(v(OP_HW, 2'd2, 16'h0010, 0));
    vecs.push_back(v(OP_HR, 2'd0, 0, 16'hBEEF));
    vecs.push_back(v(OP_HR, 2'd0, 0, 16'h1234));
    vecs.push_back(v(OP_HR, 2'd2, 0, 16'h0014));
    vecs.push_back(v(OP_HW, 2'd2, 16'hFFFE, 0));
    vecs.push_back(v(OP_HW, 2'd0, 16'hA5A5, 0));
    vecs.push_back(v(OP_HR, 2'd2, 0, 16'h0000));
    vecs.push_back(v(OP_HW, 2'd2, 16'h01FE, 0));
    vecs.push_back(v(OP_HR, 2'd0, 0, 16'hA5A5));
    vecs.push_back(v(OP_HR, 2'd2, 0, 16'h0200));
    vecs.push_back(v(OP_DW, 0, 16'h00C3, 0));
    vecs.push_back(v(OP_INT, 0, 0, 16'h0001));
    vecs.push_back(v(OP_HR, 2'd3, 0, 16'h0001));
    vecs.push_back(v(OP_HR, 2'd1, 0, 16'h00C3));
    vecs.push_back(v(OP_INT, 0, 0, 16'h0000));
    vecs.push_back(v(OP_HR, 2'd3, 0, 16'h0000));
    vecs.push_back(v(OP_HW, 2'd1, 16'h5A5A, 0));
    vecs.push_back(v(OP_MBX, 0, 16'h5A5A, 16'h0001));
    vecs.push_back(v(OP_HR, 2'd3, 0, 16'h0100));
    vecs.push_back(v(OP_ACK, 0, 0, 0));
    vecs.push_back(v(OP_MBX, 0, 16'h5A5A, 16'h0000));
    vecs.push_back(v(OP_HW, 2'd3, 16'hFFFF, 0));
    vecs.push_back(v(OP_HR, 2'd3, 0, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_HW:  host_write(vecs[i].sel, vecs[i].data, 0);
        OP_HR: begin
          host_read(vecs[i].sel, 0, 0, got, exp, known);
          check16($sformatf("vec%0d_read", i), got, vecs[i].exp);
        end
        OP_DW:  dev_write(vecs[i].data);
        OP_ACK: dev_ack();
        OP_INT: begin
          @(negedge clk);
          check16($sformatf("vec%0d_int", i), {15'b0, otg_int}, vecs[i].exp);
        end
        default: begin
          @(negedge clk);
          check16($sformatf("vec%0d_mbx_in", i), dev_mbx_in, vecs[i].data);
          check16($sformatf("vec%0d_mbx_valid", i), {15'b0, dev_mbx_in_valid}, vecs[i].exp);
        end
      endcase
    end

    // Device post on the same cycle the host mailbox read exits: flag stays set
    dev_write(16'h0077);
    host_read(2'd1, 1, 16'h0088, got, exp, known);
    check16("coll_rd_val", got, 16'h0077);
    @(negedge clk);
    check16("coll_int_kept", {15'b0, otg_int}, 16'h0001);
    host_read(2'd1, 0, 0, got, exp, known);
    check16("coll_rd_new", got, 16'h0088);
    check_side("coll_after");

    // Host mailbox write with same-cycle device ack: new value, valid stays set
    host_write(2'd1, 16'h1111, 0);
    host_write(2'd1, 16'h2222, 1);
    @(negedge clk);
    check16("ack_coll_val", dev_mbx_in, 16'h2222);
    check16("ack_coll_valid", {15'b0, dev_mbx_in_valid}, 16'h0001);
    dev_ack();

    // Write strobe held for three cycles commits exactly once
    host_write(2'd2, 16'h0040, 0);
    otg_addr = 2'd0; tb_wdata = 16'h0BAD; tb_drv = 1; cs_n = 0; wr_n = 0;
    tick(); tick(); tick();
    cs_n = 1; wr_n = 1; tb_drv = 0;
    tick();
    m_host_write(2'd0, 16'h0BAD);
    host_read(2'd2, 0, 0, got, exp, known);
    check16("long_wr_addr", got, 16'h0042);

    // Both strobes low: error flag, no access
    host_write(2'd2, 16'h0050, 0);
    host_write(2'd0, 16'h7E57, 0);
    host_write(2'd2, 16'h0050, 0);
    otg_addr = 2'd0; tb_wdata = 16'hDEAD; tb_drv = 1; cs_n = 0; rd_n = 0; wr_n = 0;
    tick();
    cs_n = 1; rd_n = 1; wr_n = 1; tb_drv = 0;
    tick();
    m_proto = 1;
    @(negedge clk);
    check16("proto_flag", {15'b0, proto_err}, 16'h0001);
    host_read(2'd2, 0, 0, got, exp, known);
    check16("proto_addr", got, 16'h0050);
    host_read(2'd0, 0, 0, got, exp, known);
    check16("proto_mem", got, 16'h7E57);
    host_read(2'd3, 0, 0, got, exp, known);
    check16("proto_status", got & 16'h8000, 16'h8000);
    do_reset();
    @(negedge clk);
    check16("proto_cleared", {15'b0, proto_err}, 16'h0000);

    // Reset during an active DATA read
    host_write(2'd2, 16'h0020, 0);
    host_write(2'd0, 16'h1111, 0);
    host_write(2'd2, 16'h0020, 0);
    otg_addr = 2'd0; cs_n = 0; rd_n = 0;
    tick();
    @(negedge clk);
    check16("rstrd_driving", otg_data, 16'h1111);
    rst = 1;
    tick();
    @(negedge clk);
    check16("rstrd_hiz", otg_data, 16'hFFFF);
    rst = 0; cs_n = 1; rd_n = 1;
    tick();
    m_reset();
    host_read(2'd2, 0, 0, got, exp, known);
    check16("rstrd_addr", got, 16'h0000);

    // Host-side target reset clears the mailbox flags
    dev_write(16'h0042);
    host_write(2'd1, 16'h0043, 0);
    otg_rst_n = 0;
    tick();
    otg_rst_n = 1;
    m_reset();
    check_side("otg_rst");

    // Randomized transactions against the model
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [15:0] rd16;
      kind = $urandom_range(0, 6);
      rd16 = 16'($urandom);
      case (kind)
        0, 1: host_write(2'd0, rd16, 0);
        2:    host_write(2'd2, 16'(($urandom_range(0, 127) << 9) + $urandom_range(0, 15) * 2), 0);
        3: begin
          logic [1:0] s;
          s = 2'($urandom_range(0, 3));
          host_read(s, 0, 0, got, exp, known);
          if (known) check16($sformatf("rand%0d_read_sel%0d", n, s), got, exp);
        end
        4:    host_write(2'($urandom_range(1, 3)) == 2'd2 ? 2'd1 : 2'd3, rd16, 0);
        5:    dev_write(rd16);
        default: dev_ack();
      endcase
      check_side($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
